ifetch: RTL
===========

Name: ifetch

Overview:
- Instruction fetch unit and read-side master of the 24-bit instruction RAM (12-bit byte address, one-cycle registered read, word stride 4).
- Holds the PC, issues sequential addresses to the instruction RAM and aligns the returned word with its address.
- Presents the word to decode over a valid/ready handshake.
- Accepts branch redirects from execute with zero bubble.

Parameters:
- RESET_ADDR, 12'h000: PC value loaded on reset; bits [1:0] must be 0.
- PC_STEP, 4: byte increment between sequential fetches.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  fetch enable; low = stop issuing new fetches.
- imem_addr  output  12  address to instruction RAM.
- imem_read_not_write  output  1  read strobe to instruction RAM; constant 1.
- imem_data  input  24  instruction RAM read data; word for the address sampled at the previous edge.
- instr_valid  output  1  instr/instr_pc hold a live instruction.
- instr_ready  input  1  decode accepts the instruction this cycle.
- instr  output  24  fetched instruction word.
- instr_pc  output  12  byte address of instr.
- redirect_valid  input  1  execute requests a PC change this cycle.
- redirect_pc  input  12  redirect target; bits [1:0] ignored (forced 00).
- instr_count  output  16  count of accepted instructions.

Behaviour:
- Clock and reset: single clock domain, clk. reset is synchronous, active-high.
- Registers:
  - pc: next address to issue.
  - resp_pc: address currently inside the RAM output register.
  - resp_valid.
  - instr_count.
- Reset values: pc = resp_pc = RESET_ADDR, resp_valid = 0, instr_count = 0.
  - Outputs during reset and the cycle after: instr_valid = 0, instr = 0, instr_pc = RESET_ADDR.
  - imem_read_not_write = 1 always, including during reset.
- Output mapping:
  - instr_valid = resp_valid & ~redirect_valid.
  - instr = instr_valid ? imem_data : 24'h0.
  - instr_pc = resp_pc.
- Derived terms:
  - stall = resp_valid & ~instr_ready & ~redirect_valid.
  - issue = run & ~stall.
- Priority per cycle: reset > redirect > stall > issue > idle.
  - Redirect (aligned target T):
    - imem_addr = T, resp_pc <= T, resp_valid <= run, pc <= T + PC_STEP.
    - The in-flight word is killed (instr_valid forced 0 this cycle).
    - The target word appears the next cycle, so there is no bubble.
  - Stall:
    - imem_addr = resp_pc; the RAM re-reads the same word, so instr stays stable.
    - pc, resp_pc and resp_valid are held.
  - Issue:
    - imem_addr = pc, resp_pc <= pc, resp_valid <= 1, pc <= pc + PC_STEP.
  - Idle (run = 0, no stall, no redirect):
    - imem_addr = pc, resp_valid <= 0, pc held.
    - An instruction already presented and accepted this cycle completes normally.
- State machine (two states, derived from run):
  - FETCH: run = 1.
  - IDLE: run = 0 and resp_valid = 0.
  - A stalled instruction remains presented after run falls, until it is accepted.
- Latency: address issued at edge N → instruction visible after edge N, in cycle N+1. Sustained throughput is 1 instr/cycle while instr_ready = 1.
- Arithmetic: pc is 12-bit modulo.
  - 0xFFC + 4 = 0x000; wrap is silent.
  - No range check against RAM depth; addresses above 0x1FF return undefined data.
- instr_count: +1 on every cycle with instr_valid & instr_ready; wraps 0xFFFF → 0x0000.
- Simultaneous redirect and stall: redirect wins; the stalled instruction is discarded and not counted.
- Reset mid-stall or mid-redirect: the next cycle is the reset state; fetch restarts at RESET_ADDR.
- Handshake rule: while instr_valid = 1 and instr_ready = 0, instr and instr_pc must not change unless redirect_valid or reset.

Test Plan:
- RAM preloaded: 0x000=24'h120010, 0x004=24'h140020, 0x008=24'h0C8000.
  - Stimulus: reset 2 cycles, then run = 1, instr_ready = 1.
  - Required: one cycle with instr_valid = 0, then (instr_pc, instr) = (0x000, 120010), (0x004, 140020), (0x008, 0C8000) on consecutive cycles; instr_count = 3.
- Stall: instr_ready = 0 for 3 cycles while instr_pc = 0x004 → instr = 24'h140020 and imem_addr = 0x004 on all 3 cycles; next accepted instr_pc = 0x008; count unchanged during the stall.
- Redirect loop: RAM 0x01C = 24'h3D0001, 0x024 = 24'h258FFD.
  - Stimulus: redirect_valid with redirect_pc = 0x01C during the cycle instr_pc = 0x024.
  - Required: instr_valid = 0 that cycle; the next cycle gives instr_pc = 0x01C, instr = 24'h3D0001; then 0x020.
- Redirect during stall: instr_ready = 0 with redirect_pc = 0x013 → the stalled word is not counted; next instr_pc = 0x010.
- Wrap: RESET_ADDR = 12'hFF8 → instr_pc sequence 0xFF8, 0xFFC, 0x000, 0x004.
- Run/reset:
  - Drop run while streaming → at most one more valid instruction, then instr_valid = 0 and pc frozen.
  - Assert reset during a stall → the next cycle has instr_valid = 0 and instr_count = 0; the first instruction after release is from RESET_ADDR.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch unit: owns the PC, streams sequential word addresses to
// the one-cycle instruction RAM, pairs each returned word with its address
// and hands it to decode.
//
// Decode handshake: a transfer happens on every cycle where instr_valid and
// instr_ready are both 1. While instr_valid=1 and instr_ready=0, instr and
// instr_pc hold steady (the RAM re-reads the same word) unless a redirect or
// reset intervenes. instr_valid never depends on instr_ready.
module ifetch #(
  parameter logic [11:0] RESET_ADDR = 12'h000,
  parameter int          PC_STEP    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [11:0] imem_addr,
  output logic        imem_read_not_write,
  input  logic [23:0] imem_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [23:0] instr,
  output logic [11:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [11:0] redirect_pc,
  output logic [15:0] instr_count,
  output logic        state_dbg
);

  localparam logic [11:0] STEP = 12'(PC_STEP);

  // FETCH while fetching or still presenting a word; IDLE once fully drained.
  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [11:0] pc;
  logic [11:0] pc_next;
  logic [11:0] resp_pc;
  logic [11:0] resp_pc_next;
  logic        resp_valid;
  logic        resp_valid_next;
  logic [11:0] redirect_target;
  logic        stall;
  logic        accept;

  // Redirect targets are always word aligned; low bits are dropped.
  assign redirect_target = redirect_pc & 12'hFFC;

  // A redirect kills the word in flight, so it never stalls the pipe.
  assign stall  = resp_valid & ~instr_ready & ~redirect_valid;

  // Reset masks the presented word even if one was live before reset.
  assign instr_valid = resp_valid & ~redirect_valid & ~reset;
  assign instr       = instr_valid ? imem_data : 24'h0;
  assign instr_pc    = reset ? RESET_ADDR : resp_pc;
  assign accept      = instr_valid & instr_ready;

  assign imem_read_not_write = 1'b1;
  assign state_dbg           = state;

  // Next-state selection: redirect > stall > issue > idle; reset in the register.
  always_comb begin
    pc_next         = pc;
    resp_pc_next    = resp_pc;
    resp_valid_next = resp_valid;
    imem_addr       = pc;
    if (reset) begin
      imem_addr = RESET_ADDR;
    end else if (redirect_valid) begin
      imem_addr       = redirect_target;
      resp_pc_next    = redirect_target;
      resp_valid_next = run;
      pc_next         = redirect_target + STEP;
    end else if (stall) begin
      // Re-read the held address so the RAM output register keeps the word.
      imem_addr = resp_pc;
    end else if (run) begin
      resp_pc_next    = pc;
      resp_valid_next = 1'b1;
      pc_next         = pc + STEP;
    end else begin
      resp_valid_next = 1'b0;
    end
    state_next = (run || resp_valid_next) ? FETCH : IDLE;
  end

  // PC, response tracking and FSM state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_ADDR;
      resp_pc    <= RESET_ADDR;
      resp_valid <= 1'b0;
      state      <= IDLE;
    end else begin
      pc         <= pc_next;
      resp_pc    <= resp_pc_next;
      resp_valid <= resp_valid_next;
      state      <= state_next;
    end
  end

  // Accepted-instruction counter; wraps silently at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count <= 16'h0000;
    end else if (accept) begin
      instr_count <= instr_count + 16'h0001;
    end
  end

endmodule
